// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants for the configurable UART transmitter:
//                FSM state encoding, parity-mode selectors and the helper
//                functions used to size the bit-period divider.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Transmitter FSM encoding (six states, three bits).
   localparam int         STATE_W     = 3;
   localparam logic [2:0] c_ST_IDLE   = 3'd0;
   localparam logic [2:0] c_ST_FETCH  = 3'd1;
   localparam logic [2:0] c_ST_START  = 3'd2;
   localparam logic [2:0] c_ST_DATA   = 3'd3;
   localparam logic [2:0] c_ST_PARITY = 3'd4;
   localparam logic [2:0] c_ST_STOP   = 3'd5;

   // Parity-mode selectors for the PARITY parameter.
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
   function automatic int clog2(input int value);
      int v;
      int r;
      r = 0;
      if (value > 1) begin
         v = value - 1;
         while (v > 0) begin
            r = r + 1;
            v = v >> 1;
         end
      end
      return r;
   endfunction

   // Width of a counter that must hold 0..div-1 (never narrower than 1 bit).
   function automatic int div_width(input int div);
      return (clog2(div) < 1) ? 1 : clog2(div);
   endfunction

   // Rounded clocks-per-bit; 0 flags an unusable baud rate.
   function automatic int calc_div(input longint clk_hz, input longint baud);
      if (baud <= 0) begin
         return 0;
      end
      return int'((clk_hz + (baud / 2)) / baud);
   endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period counter producing a one-cycle clock-enable tick
//                every DIV cycles. i_restart holds the count at zero so the
//                first tick after release lands exactly DIV cycles later.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                i_restart - synchronous counter restart
//                o_tick    - high for one cycle at the end of each period
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen #(
   parameter int DIV   = 16,
   parameter int CNT_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   assign w_at_last = (r_cnt == c_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_restart) begin
         r_cnt <= '0;
      end else if (w_at_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // A restart in the same cycle as the terminal count wins over the tick.
   assign o_tick = w_at_last && !i_restart;

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_cfg
//  Description : Parameterised UART transmitter fed from a FIFO with a
//                one-cycle read latency. Frame = start, DATA_BITS data (LSB
//                first), optional parity, STOP_BITS stop bits. Back-to-back
//                frames are fetched at stop end with a 2-cycle line gap.
//  Ports       : clk       - system clock (rising edge)
//                rst       - synchronous active-high reset
//                readEn    - FIFO pop strobe (registered, one cycle)
//                dout      - FIFO read data, valid the cycle after readEn
//                empty     - FIFO empty flag
//                txData    - serial line, idle high (registered)
//                busy      - high from pop until end of last stop bit
//                frameDone - one-cycle pulse at end of each frame
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 50000000,
   parameter int BAUD_RATE = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 readEn,
   input  logic [DATA_BITS-1:0] dout,
   input  logic                 empty,
   output logic                 txData,
   output logic                 busy,
   output logic                 frameDone
);

   localparam int DIV   = calc_div(longint'(CLK_HZ), longint'(BAUD_RATE));
   localparam int CNT_W = div_width(DIV);

   localparam logic [3:0] c_LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       c_LAST_STOP = 1'(STOP_BITS - 1);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter guard
   // ------------------------------------------------------------------------
   if ((CLK_HZ <= 0) || (BAUD_RATE <= 0) || (DIV < 2) ||
       (DATA_BITS < 5) || (DATA_BITS > 9) ||
       ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) ||
       ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_param_check
      $error("uart_tx_cfg: illegal parameter combination");
   end

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [STATE_W-1:0]   r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [3:0]           r_bitCnt;
   logic                 r_stopCnt;
   logic                 r_parity;
   logic                 r_txData;
   logic                 r_readEn;
   logic                 r_busy;
   logic                 r_frameDone;

   logic                 w_restart;
   logic                 w_tick;
   logic                 w_parity;

   // Holding the divider in reset through FETCH makes the start bit exactly
   // DIV cycles long, independent of where the free-running count was.
   assign w_restart = (r_state == c_ST_FETCH);

   // Parity covers the data bits only. Odd mode inverts the XOR so the total
   // number of ones (data + parity) comes out odd.
   assign w_parity = (PARITY == PAR_ODD) ? ~(^dout) : (^dout);

   uart_baud_gen #(
      .DIV   (DIV),
      .CNT_W (CNT_W)
   ) u_baud_gen (
      .clk       (clk),
      .rst       (rst),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // ------------------------------------------------------------------------
   // Transmit FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= c_ST_IDLE;
         r_shift     <= '0;
         r_bitCnt    <= '0;
         r_stopCnt   <= 1'b0;
         r_parity    <= 1'b0;
         r_txData    <= 1'b1;
         r_readEn    <= 1'b0;
         r_busy      <= 1'b0;
         r_frameDone <= 1'b0;
      end else begin
         r_readEn    <= 1'b0;
         r_frameDone <= 1'b0;

         case (r_state)
            c_ST_IDLE: begin
               r_txData <= 1'b1;
               if (!empty) begin
                  r_readEn <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= c_ST_FETCH;
               end
            end

            // Two cycles: the first is the pop itself (readEn high), the
            // second is when the FIFO presents the popped word on dout.
            c_ST_FETCH: begin
               if (!r_readEn) begin
                  r_shift   <= dout;
                  r_parity  <= w_parity;
                  r_bitCnt  <= '0;
                  r_stopCnt <= 1'b0;
                  r_txData  <= 1'b0;
                  r_state   <= c_ST_START;
               end
            end

            c_ST_START: begin
               if (w_tick) begin
                  r_txData <= r_shift[0];
                  r_shift  <= r_shift >> 1;
                  r_state  <= c_ST_DATA;
               end
            end

            c_ST_DATA: begin
               if (w_tick) begin
                  if (r_bitCnt == c_LAST_BIT) begin
                     if (PARITY != PAR_NONE) begin
                        r_txData <= r_parity;
                        r_state  <= c_ST_PARITY;
                     end else begin
                        r_txData <= 1'b1;
                        r_state  <= c_ST_STOP;
                     end
                  end else begin
                     r_bitCnt <= r_bitCnt + 4'd1;
                     r_txData <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                  end
               end
            end

            c_ST_PARITY: begin
               if (w_tick) begin
                  r_txData <= 1'b1;
                  r_state  <= c_ST_STOP;
               end
            end

            // Stop end: frameDone and, if more data waits, the next pop go
            // out together so busy never drops between chained frames.
            c_ST_STOP: begin
               if (w_tick) begin
                  if (r_stopCnt == c_LAST_STOP) begin
                     r_frameDone <= 1'b1;
                     r_stopCnt   <= 1'b0;
                     if (!empty) begin
                        r_readEn <= 1'b1;
                        r_state  <= c_ST_FETCH;
                     end else begin
                        r_busy  <= 1'b0;
                        r_state <= c_ST_IDLE;
                     end
                  end else begin
                     r_stopCnt <= r_stopCnt + 1'b1;
                  end
               end
            end

            default: begin
               r_txData <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign txData    = r_txData;
   assign readEn    = r_readEn;
   assign busy      = r_busy;
   assign frameDone = r_frameDone;

endmodule : uart_tx_cfg
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_cfg
//  Description : Scoreboard bench for uart_tx_cfg. Five instances cover
//                8N1, 8E1, 8O1, 8N2 and 9E1 at DIV = 16. Stimulus loads a
//                per-instance FIFO model and queues the hand-computed line
//                pattern; a per-instance monitor pops and checks each frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

   localparam int NI = 5;
   localparam int BT = 16;   // clocks per bit
   localparam int DB  [NI] = '{8, 8, 8, 8, 9};
   localparam int PAR [NI] = '{0, 2, 1, 0, 2};
   localparam int SB  [NI] = '{1, 1, 1, 2, 1};

   typedef struct packed {
      int          inst;
      int          nbits;
      logic [12:0] bits;   // line pattern, bit 0 = start bit
      logic        b2b;    // must follow previous frame with no idle
      logic        abort;  // frame will be cut by reset
   } exp_t;

   logic       clk;
   logic       rst;
   logic       txd    [NI];
   logic       rde    [NI];
   logic       bsy    [NI];
   logic       fdn    [NI];
   logic       fempty [NI];
   int         pops_a [NI];
   int         ill_a  [NI];
   logic [8:0] fmem   [NI][8];
   int         wp     [NI];

   exp_t       exp_q[$];
   int         total;
   int         bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
      end
   endtask

   // ------------------------------------------------------------------------
   // DUTs, FIFO models and monitors
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < NI; g++) begin : g_dut
      int         rp;
      int         pops;
      int         illegal;
      logic [8:0] dq;

      assign fempty[g] = (wp[g] == rp);
      assign pops_a[g] = pops;
      assign ill_a[g]  = illegal;

      // Registered-read FIFO: data appears the cycle after the pop.
      always @(posedge clk) begin
         if (rde[g]) begin
            pops <= pops + 1;
            if (wp[g] == rp) begin
               illegal <= illegal + 1;
            end else begin
               dq <= fmem[g][rp];
               rp <= rp + 1;
            end
         end
      end

      uart_tx_cfg #(
         .CLK_HZ    (16),
         .BAUD_RATE (1),
         .DATA_BITS (DB[g]),
         .PARITY    (PAR[g]),
         .STOP_BITS (SB[g])
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .readEn    (rde[g]),
         .dout      (dq[DB[g]-1:0]),
         .empty     (fempty[g]),
         .txData    (txd[g]),
         .busy      (bsy[g]),
         .frameDone (fdn[g])
      );

      initial begin : mon
         exp_t        e;
         logic        prev;
         logic        aborted;
         logic        done_end;
         logic [12:0] obs;
         int          cyc;
         int          start_cyc;
         int          last_done;
         int          busy_low;
         int          errs;
         prev      = 1'b1;
         cyc       = 0;
         last_done = -100;
         busy_low  = 0;
         forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
               prev = 1'b1;
            end else if (prev && !txd[g]) begin
               if (exp_q.size() == 0 || exp_q[0].inst != g) begin
                  chk($sformatf("unexpected_frame[%0d]", g), 1, 0);
               end else begin
                  e         = exp_q.pop_front();
                  start_cyc = cyc;
                  errs      = 0;
                  obs       = '0;
                  aborted   = 1'b0;
                  done_end  = 1'b0;
                  if (e.b2b) begin
                     chk($sformatf("b2b_gap_le2[%0d]", g),
                         int'((start_cyc - last_done) >= 1 && (start_cyc - last_done) <= 2), 1);
                     chk($sformatf("b2b_busy_low_cycles[%0d]", g), busy_low, 0);
                  end
                  for (int t = 0; t <= e.nbits * BT; t++) begin
                     if (t > 0) begin
                        @(negedge clk);
                        cyc++;
                     end
                     if (rst) begin
                        aborted = 1'b1;
                        break;
                     end
                     if (t < e.nbits * BT) begin
                        if (txd[g] !== e.bits[t / BT] || fdn[g] || !bsy[g]) errs++;
                        if (t % BT == BT / 2) obs[t / BT] = txd[g];
                     end else begin
                        done_end  = fdn[g];
                        last_done = cyc;
                        busy_low  = bsy[g] ? 0 : 1;
                     end
                  end
                  if (aborted) begin
                     if (!e.abort) chk($sformatf("unexpected_abort[%0d]", g), 1, 0);
                  end else if (e.abort) begin
                     chk($sformatf("frame_not_aborted[%0d]", g), 0, 1);
                  end else begin
                     chk($sformatf("line_bits[%0d]", g), int'(obs), int'(e.bits));
                     chk($sformatf("line_bad_cycles[%0d]", g), errs, 0);
                     chk($sformatf("frameDone_at_end[%0d]", g), int'(done_end), 1);
                  end
               end
            end else if (!bsy[g]) begin
               busy_low++;
            end
            if (!rst && fdn[g] && !(prev && !txd[g]) && cyc != last_done)
               chk($sformatf("stray_frameDone[%0d]", g), 1, 0);
            prev = rst ? 1'b1 : txd[g];
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic push_word(input int i, input logic [8:0] w, input logic [12:0] line,
                            input int nbits, input logic b2b, input logic abort);
      exp_t e;
      e.inst  = i;
      e.nbits = nbits;
      e.bits  = line;
      e.b2b   = b2b;
      e.abort = abort;
      exp_q.push_back(e);
      fmem[i][wp[i]] = w;
      wp[i]          = wp[i] + 1;
   endtask

   task automatic wait_quiet(input int i, input int budget, input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bsy[i]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) chk({name, "_timeout"}, 1, 0);
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input int i, input logic [8:0] w, input logic [12:0] line,
                       input int nbits, input string name);
      int p0;
      p0 = pops_a[i];
      push_word(i, w, line, nbits, 1'b0, 1'b0);
      wait_quiet(i, 400, name);
      chk({name, "_readEn_count"}, pops_a[i] - p0, 1);
   endtask

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin : main
      int p0;
      int p1;
      int n_rd;
      int n_low;
      int n_busy;
      int n;
      total = 0;
      bad   = 0;
      rst   = 1'b1;

      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++)
         chk($sformatf("reset_tx_rd_busy_done[%0d]", i),
             int'({txd[i], rde[i], bsy[i], fdn[i]}), 4'b1000);
      rst = 1'b0;

      // All FIFOs empty for 1000 cycles: nothing may move.
      n_rd = 0; n_low = 0; n_busy = 0;
      repeat (1000) begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            if (rde[i]) n_rd++;
            if (!txd[i]) n_low++;
            if (bsy[i]) n_busy++;
         end
      end
      chk("idle_readEn_pulses", n_rd, 0);
      chk("idle_line_low", n_low, 0);
      chk("idle_busy_high", n_busy, 0);

      // 8N1
      send(0, 9'h055, 13'h2AA, 10, "8N1_55");
      send(0, 9'h080, 13'h300, 10, "8N1_80");
      // 8E1 / 8O1: 0x07 has three ones
      send(1, 9'h007, 13'h60E, 11, "8E1_07");
      send(1, 9'h000, 13'h400, 11, "8E1_00");
      send(2, 9'h007, 13'h40E, 11, "8O1_07");
      send(2, 9'h000, 13'h600, 11, "8O1_00");
      // 9E1: nine ones -> even parity bit 1
      send(4, 9'h1FF, 13'hFFE, 12, "9E1_1FF");

      // 8N2 back-to-back pair
      p0 = pops_a[3];
      push_word(3, 9'h0A5, 13'h74A, 11, 1'b0, 1'b0);
      push_word(3, 9'h03C, 13'h678, 11, 1'b1, 1'b0);
      wait_quiet(3, 800, "8N2_pair");
      chk("8N2_readEn_count", pops_a[3] - p0, 2);

      // Reset 50 cycles into a frame
      p1 = pops_a[0];
      push_word(0, 9'h055, 13'h2AA, 10, 1'b0, 1'b1);
      n = 0;
      while (txd[0] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("rst_frame_start_timeout", 1, 0);
      repeat (50) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_tx_high", int'(txd[0]), 1);
      chk("rst_mid_busy_low", int'(bsy[0]), 0);
      n_rd = rde[0] ? 1 : 0;
      repeat (3) begin
         @(negedge clk);
         if (rde[0]) n_rd++;
      end
      chk("rst_mid_readEn_during_rst", n_rd, 0);
      rst = 1'b0;
      n_low = 0; n_busy = 0;
      repeat (100) begin
         @(negedge clk);
         if (!txd[0]) n_low++;
         if (bsy[0]) n_busy++;
      end
      chk("post_rst_line_low", n_low, 0);
      chk("post_rst_busy_high", n_busy, 0);
      chk("rst_single_pop", pops_a[0] - p1, 1);
      chk("rst_exp_queue_drained", exp_q.size(), 0);

      n = 0;
      for (int i = 0; i < NI; i++) n += ill_a[i];
      chk("pop_while_empty", n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_uart_tx_cfg
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame, legal values 1 or 2.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port readEn, output, 1 bit: FIFO pop strobe, one clk cycle wide.
REQ-009 SHALL have port dout, input, DATA_BITS bits: FIFO read data, valid the cycle after readEn.
REQ-010 SHALL have port empty, input, 1 bit: FIFO empty flag.
REQ-011 SHALL have port txData, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high from pop until end of last stop bit.
REQ-013 SHALL have port frameDone, output, 1 bit: one-cycle pulse at the end of each frame.

Function
REQ-014 SHALL derive the bit period DIV = round(CLK_HZ/BAUD_RATE) clk cycles; DIV < 2 or illegal parameters SHALL fail elaboration.
REQ-015 SHALL use a clock-enable baud tick, with no derived clock; the tick counter restarts at the start of every frame.
REQ-016 SHALL implement states IDLE, FETCH, START, DATA, PARITY, STOP.
REQ-017 In IDLE with empty=0 sampled, SHALL drive readEn high the next cycle and enter FETCH.
REQ-018 FETCH SHALL capture dout into the shift register, compute parity, and enter START; txData SHALL fall on the following cycle.
REQ-019 START SHALL hold txData=0 for DIV cycles.
REQ-020 DATA SHALL send DATA_BITS bits, LSB first, DIV cycles each.
REQ-021 PARITY SHALL be skipped when PARITY=0; otherwise it SHALL send one bit over the data bits only (odd: total ones odd; even: total ones even).
REQ-022 STOP SHALL hold txData=1 for STOP_BITS*DIV cycles, then pulse frameDone for one cycle.
REQ-023 At STOP end with empty=0, SHALL pulse readEn in the same cycle as frameDone and enter FETCH (back-to-back, max 2-cycle inter-frame gap); with empty=1, SHALL return to IDLE.
REQ-024 SHALL never assert readEn while empty=1 or outside IDLE/STOP-end; exactly one readEn per frame.
REQ-025 SHALL ignore changes on dout and empty after capture until the next STOP end.
REQ-026 txData, readEn and frameDone SHALL be registered outputs (glitch-free).

Reset
REQ-027 While rst=1: txData=1, readEn=0, busy=0, frameDone=0, state=IDLE, counters=0.
REQ-028 rst mid-frame SHALL abandon the frame; txData SHALL be 1 on the cycle after rst is sampled; the popped word SHALL be lost with no re-pop.

Structure
REQ-029 Package uart_pkg SHALL hold the state encoding, the parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and a divider-width function (clog2).
REQ-030 Sub-module uart_baud_gen SHALL provide the DIV counter with synchronous restart and a one-cycle tick output.

Verification (CLK_HZ=16, BAUD_RATE=1, so DIV=16, unless stated)
REQ-031 8N1, FIFO holds 0x55 -> txData 0,1,0,1,0,1,0,1,0,1, each 16 cycles; frameDone once after 160 cycles; one readEn.
REQ-032 8E1 and 8O1 with 0x07 -> parity bit 1 (even) / 0 (odd), at cycles 144..159 of the frame.
REQ-033 8N2, FIFO holds 0xA5, 0x3C -> stop high 32 cycles; second start bit begins ≤2 cycles after first frameDone; exactly 2 readEn pulses; busy continuous.
REQ-034 rst=1 at cycle 50 of a frame -> txData=1 next cycle, busy=0, no readEn during rst; after release with empty=1, line stays high.
REQ-035 empty=1 held for 1000 cycles -> readEn never asserted, txData=1, busy=0.
REQ-036 DATA_BITS=9, PARITY=2, word 0x1FF -> 9 ones, parity 1, frame length 12*16 cycles.
